// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the MIPS fetch slice
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'd160;
  localparam logic [31:0] INSTR_NOP          = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES         = 32'd4;
  localparam int          IMEM_DEPTH_DEFAULT = 250;

  // Selects where the program counter comes from on the next edge.
  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_STEP     = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  // Clears the byte-offset bits so every fetch address is a word address.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~(WORD_BYTES - 32'd1);
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter register with redirect / step / hold select
module fetch_pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        advance,
  output logic [31:0] pc
);

  pc_sel_e     pc_sel;
  logic [31:0] pc_next;

  // Redirect wins over everything; otherwise step only when the IF/ID slot can take a word.
  always_comb begin
    pc_sel = PC_HOLD;
    if (redirect) begin
      pc_sel = PC_REDIRECT;
    end else if (advance) begin
      pc_sel = PC_STEP;
    end
  end

  // Next-pc mux; the step wraps modulo 2^32 without any flag.
  always_comb begin
    pc_next = pc;
    case (pc_sel)
      PC_REDIRECT: pc_next = word_align(redirect_target);
      PC_STEP:     pc_next = pc + WORD_BYTES;
      default:     pc_next = pc;
    endcase
  end

  // Program counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, IF/ID register, range check; optional MISALIGN_TRAP_EN
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          IMEM_DEPTH = IMEM_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  input  logic        redirect,
  input  logic [31:0] redirect_target
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign_err
`endif
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_DEPTH) * WORD_BYTES;

  logic [31:0] pc;
  logic        advance;
  logic        in_range;
  logic [31:0] fetched_word;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .advance         (advance),
    .pc              (pc)
  );

  // A new word may enter IF/ID when the slot is empty or decode is taking the current one.
  always_comb begin
    imem_addr    = pc;
    advance      = !if_valid || if_ready;
    in_range     = pc < IMEM_LIMIT;
    fetched_word = in_range ? imem_instr : INSTR_NOP;
  end

  // IF/ID register: redirect flushes, advance captures, otherwise hold stable for decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid    <= 1'b0;
      if_instr    <= INSTR_NOP;
      if_pc       <= 32'd0;
      if_pc_plus4 <= 32'd0;
    end else if (redirect) begin
      if_valid <= 1'b0;
    end else if (advance) begin
      if_valid    <= 1'b1;
      if_instr    <= fetched_word;
      if_pc       <= pc;
      if_pc_plus4 <= pc + WORD_BYTES;
    end
  end

`ifdef MISALIGN_TRAP_EN
  // One-cycle error pulse for a redirect whose target is not word aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect && (redirect_target[1:0] != 2'b00);
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        redirect;
  logic [31:0] redirect_target;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int checks;
  int failures;

  instruction_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4),
    .redirect        (redirect),
    .redirect_target (redirect_target)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign_err    (misalign_err)
`endif
  );

  // memory contents: a recognisable function of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  assign imem_instr = mem_word(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model of the fetch stage
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic        m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc    <= 32'd160;
      m_valid <= 1'b0;
      m_instr <= 32'd0;
      m_ipc   <= 32'd0;
      m_err   <= 1'b0;
    end else begin
      m_err <= redirect && (redirect_target % 4 != 0);
      if (redirect) begin
        m_pc    <= redirect_target - (redirect_target % 4);
        m_valid <= 1'b0;
      end else if (!m_valid || if_ready) begin
        m_valid <= 1'b1;
        m_ipc   <= m_pc;
        m_instr <= (m_pc < 250 * 4) ? mem_word(m_pc) : 32'd0;
        m_pc    <= m_pc + 4;
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    chk("cyc_addr", imem_addr, m_pc);
    chk("cyc_valid", {31'd0, if_valid}, {31'd0, m_valid});
    if (m_valid) begin
      chk("cyc_instr", if_instr, m_instr);
      chk("cyc_pc", if_pc, m_ipc);
      chk("cyc_pc4", if_pc_plus4, m_ipc + 32'd4);
    end
`ifdef MISALIGN_TRAP_EN
    chk("cyc_err", {31'd0, misalign_err}, {31'd0, m_err});
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect        = 1'b1;
    redirect_target = t;
    step();
    redirect        = 1'b0;
  endtask

  initial begin
    int n;
    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    if_ready        = 1'b1;
    redirect        = 1'b0;
    redirect_target = 32'd0;
    step();
    chk("rst_addr", imem_addr, 32'd160);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    rst_n = 1'b1;

    // first fetch
    step();
    chk("t1_valid", {31'd0, if_valid}, 32'd1);
    chk("t1_pc", if_pc, 32'd160);
    chk("t1_pc4", if_pc_plus4, 32'd164);
    chk("t1_instr", if_instr, 32'hA500_00A0);
    chk("t1_addr", imem_addr, 32'd164);

    // stall three cycles
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold_pc", if_pc, 32'd160);
      chk("t2_hold_addr", imem_addr, 32'd164);
    end
    if_ready = 1'b1;
    step();
    chk("t2_resume_pc", if_pc, 32'd164);
    chk("t2_resume_addr", imem_addr, 32'd168);

    // run to if_pc = 196 (bounded)
    n = 0;
    while (if_pc != 32'd196 && n < 20) begin
      step();
      n++;
    end
    chk("t3_reach196", if_pc, 32'd196);
    do_redirect(32'd160);
    chk("t3_flush_valid", {31'd0, if_valid}, 32'd0);
    chk("t3_flush_addr", imem_addr, 32'd160);
    step();
    chk("t3_refetch_pc", if_pc, 32'd160);
    chk("t3_refetch_valid", {31'd0, if_valid}, 32'd1);

    // redirect while stalled
    if_ready = 1'b0;
    step();
    do_redirect(32'd160);
    chk("t3s_flush_valid", {31'd0, if_valid}, 32'd0);
    chk("t3s_flush_addr", imem_addr, 32'd160);
    step();
    chk("t3s_refetch_pc", if_pc, 32'd160);
    chk("t3s_refetch_valid", {31'd0, if_valid}, 32'd1);
    if_ready = 1'b1;

    // out of range
    do_redirect(32'd1000);
    step();
    chk("t4_pc", if_pc, 32'd1000);
    chk("t4_instr", if_instr, 32'd0);
    chk("t4_valid", {31'd0, if_valid}, 32'd1);

    // misaligned target
    do_redirect(32'd162);
    chk("t5_addr", imem_addr, 32'd160);
`ifdef MISALIGN_TRAP_EN
    chk("t5_err_hi", {31'd0, misalign_err}, 32'd1);
`endif
    step();
`ifdef MISALIGN_TRAP_EN
    chk("t5_err_lo", {31'd0, misalign_err}, 32'd0);
`endif
    chk("t5_pc", if_pc, 32'd160);

    // back-to-back redirects
    redirect = 1'b1;
    redirect_target = 32'd200;
    step();
    chk("b2b_valid1", {31'd0, if_valid}, 32'd0);
    redirect_target = 32'd300;
    step();
    chk("b2b_valid2", {31'd0, if_valid}, 32'd0);
    chk("b2b_addr", imem_addr, 32'd300);
    redirect = 1'b0;
    step();
    chk("b2b_pc", if_pc, 32'd300);

    // wrap and reset mid-stall
    do_redirect(32'hFFFF_FFFC);
    chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("t6_wrap_addr", imem_addr, 32'd0);
    chk("t6_wrap_pc4", if_pc_plus4, 32'd0);
    chk("t6_wrap_instr", if_instr, 32'd0);
    if_ready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_addr", imem_addr, 32'd160);
    chk("t6_rst_valid", {31'd0, if_valid}, 32'd0);
    step();
    rst_n = 1'b1;
    if_ready = 1'b1;
    step();
    chk("t6_after_pc", if_pc, 32'd160);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
